// File: rtl/hmmm_mem_loader.sv
// 256x15 unified memory: a byte-serial loader fills it and holds the CPU in reset, then it serves CPU fetches, loads and stores.
// Reads are combinational; load_ready is a state decode, so load_valid gaps stall the loader without any state change.
module hmmm_mem_loader #(
  parameter int DEPTH = 256
) (
  input  logic       ph1,
  input  logic       reset,
  input  logic       load_valid,
  input  logic [7:0] load_byte,
  output logic       load_ready,
  output logic       cpu_reset,
  output logic       load_done,
  output logic       load_err,
  input  logic [7:0] Adr,
  input  logic       MemWrite,
  input  logic [7:0] wr_data,
  output logic [6:0] MemData1,
  output logic [7:0] rd_data,
  output logic       rd_drive
);

  typedef enum logic [2:0] {HDR, HI, LO, RUN, ERR} state_t;

  state_t      state_q, state_d;
  logic [8:0]  count_q, count_d;
  logic [8:0]  waddr_q, waddr_d;
  logic [6:0]  hi_q, hi_d;
  logic [14:0] mem_q [DEPTH];

  logic        accept;
  logic        mem_we;
  logic [7:0]  mem_wadr;
  logic [14:0] mem_wdat;
  logic [14:0] rd_word;

  assign rd_word    = mem_q[Adr];
  assign MemData1   = rd_word[14:8];
  assign rd_data    = rd_word[7:0];

  assign load_ready = (state_q == HDR) || (state_q == HI) || (state_q == LO);
  assign load_done  = (state_q == RUN);
  assign load_err   = (state_q == ERR);
  assign cpu_reset  = ~load_done;
  assign rd_drive   = load_done & ~MemWrite;
  assign accept     = load_valid & load_ready;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    waddr_d  = waddr_q;
    hi_d     = hi_q;
    mem_we   = 1'b0;
    mem_wadr = 8'd0;
    mem_wdat = 15'd0;
    case (state_q)
      HDR: begin
        if (accept) begin
          // A zero header means a full 256-word image.
          count_d = (load_byte == 8'd0) ? 9'd256 : {1'b0, load_byte};
          waddr_d = 9'd0;
          state_d = HI;
        end
      end
      HI: begin
        if (accept) begin
          if (load_byte[7]) begin
            state_d = ERR;
          end else begin
            hi_d    = load_byte[6:0];
            state_d = LO;
          end
        end
      end
      LO: begin
        if (accept) begin
          mem_we   = 1'b1;
          mem_wadr = waddr_q[7:0];
          mem_wdat = {hi_q, load_byte};
          waddr_d  = waddr_q + 9'd1;
          state_d  = (waddr_q == count_q - 9'd1) ? RUN : HI;
        end
      end
      RUN: begin
        // CPU stores only replace the low byte of the word.
        if (MemWrite) begin
          mem_we   = 1'b1;
          mem_wadr = Adr;
          mem_wdat = {rd_word[14:8], wr_data};
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = HDR;
      end
    endcase
  end

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state_q <= HDR;
      count_q <= 9'd0;
      waddr_q <= 9'd0;
      hi_q    <= 7'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      waddr_q <= waddr_d;
      hi_q    <= hi_d;
    end
  end

  // The array itself is deliberately not reset.
  always_ff @(posedge ph1) begin
    if (mem_we) begin
      mem_q[mem_wadr] <= mem_wdat;
    end
  end

endmodule

// File: tb/tb_hmmm_mem_loader.sv
// Directed bench for hmmm_mem_loader: loads, full-depth load, header error, gaps, CPU store, async reset.
module tb_hmmm_mem_loader;

  logic       ph1 = 1'b0;
  logic       reset = 1'b1;
  logic       load_valid = 1'b0;
  logic [7:0] load_byte = 8'd0;
  logic       load_ready, cpu_reset, load_done, load_err;
  logic [7:0] Adr = 8'd0;
  logic       MemWrite = 1'b0;
  logic [7:0] wr_data = 8'd0;
  logic [6:0] MemData1;
  logic [7:0] rd_data;
  logic       rd_drive;

  int n_cmp = 0;
  int n_err = 0;

  hmmm_mem_loader dut (
    .ph1(ph1), .reset(reset),
    .load_valid(load_valid), .load_byte(load_byte), .load_ready(load_ready),
    .cpu_reset(cpu_reset), .load_done(load_done), .load_err(load_err),
    .Adr(Adr), .MemWrite(MemWrite), .wr_data(wr_data),
    .MemData1(MemData1), .rd_data(rd_data), .rd_drive(rd_drive)
  );

  always #5 ph1 = ~ph1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One byte offered for exactly one rising edge.
  task automatic send(input logic [7:0] b);
    @(negedge ph1);
    load_valid = 1'b1;
    load_byte  = b;
    @(posedge ph1);
    #1;
    load_valid = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a, input logic [14:0] exp);
    @(negedge ph1);
    Adr = a;
    #1;
    check_eq(tag, {17'd0, MemData1, rd_data}, {17'd0, exp});
  endtask

  // Reset lands between edges so the checks prove it is asynchronous.
  task automatic do_reset(input string tag);
    @(negedge ph1);
    #2 reset = 1'b0;
    #1;
    check_eq({tag, "_cpu_reset"}, cpu_reset, 1);
    check_eq({tag, "_ready"}, load_ready, 1);
    check_eq({tag, "_done"}, load_done, 0);
    check_eq({tag, "_err"}, load_err, 0);
    @(negedge ph1);
    reset = 1'b1;
  endtask

  initial begin
    logic [7:0] b;

    do_reset("rst0");

    // Three-word image.
    send(8'd3);
    send(8'h00); send(8'h15); send(8'h7F); send(8'hFF); send(8'h01);
    check_eq("t1_cpu_reset_6", cpu_reset, 1);
    send(8'h80);
    check_eq("t1_cpu_reset_7", cpu_reset, 0);
    check_eq("t1_done", load_done, 1);
    check_eq("t1_ready", load_ready, 0);
    rd_check("t1_m0", 8'd0, 15'h0015);
    check_eq("t1_rd_drive", rd_drive, 1);
    rd_check("t1_m1", 8'd1, 15'h7FFF);
    rd_check("t1_m2", 8'd2, 15'h0180);

    do_reset("rst_run");

    // 33 words; word 0x20 is 0x5A3C, then a CPU store to it.
    send(8'd33);
    for (int i = 0; i < 32; i++) begin
      b = 8'(i);
      send({1'b0, b[6:0]});
      send(b);
    end
    send(8'h5A); send(8'h3C);
    check_eq("t3_done", load_done, 1);
    rd_check("t3_m1f", 8'h1F, 15'h1F1F);
    rd_check("t3_m20", 8'h20, 15'h5A3C);
    @(negedge ph1);
    MemWrite = 1'b1;
    wr_data  = 8'h77;
    #1;
    check_eq("t3_rd_drive_st", rd_drive, 0);
    check_eq("t3_old_data", {17'd0, MemData1, rd_data}, 32'h5A3C);
    @(posedge ph1);
    #1;
    MemWrite = 1'b0;
    rd_check("t3_m20_st", 8'h20, 15'h5A77);

    do_reset("rst_full");

    // Full 256-word image via header 0.
    send(8'd0);
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      send({1'b0, b[6:0]});
      if (i == 255) check_eq("t4_pre_last", cpu_reset, 1);
      send(b);
    end
    check_eq("t4_done", load_done, 1);
    send(8'h11); send(8'h22);
    rd_check("t4_m0", 8'd0, 15'h0000);
    rd_check("t4_m1", 8'd1, 15'h0101);
    rd_check("t4_m128", 8'd128, 15'h0080);
    rd_check("t4_m255", 8'd255, 15'h7FFF);

    do_reset("rst_gap");

    // Gapped load, then load_valid held high in RUN.
    send(8'd3);
    send(8'h12); repeat ($urandom_range(1, 4)) @(negedge ph1);
    send(8'h34); repeat ($urandom_range(1, 4)) @(negedge ph1);
    send(8'h56); repeat ($urandom_range(1, 4)) @(negedge ph1);
    send(8'h78); repeat ($urandom_range(1, 4)) @(negedge ph1);
    send(8'h0A);
    check_eq("t5_stall", cpu_reset, 1);
    repeat ($urandom_range(1, 4)) @(negedge ph1);
    send(8'hBC);
    check_eq("t5_done", load_done, 1);
    @(negedge ph1);
    load_valid = 1'b1;
    load_byte  = 8'h55;
    repeat (8) @(posedge ph1);
    #1;
    load_valid = 1'b0;
    check_eq("t5_still_run", load_done, 1);
    rd_check("t5_m0", 8'd0, 15'h1234);
    rd_check("t5_m1", 8'd1, 15'h5678);
    rd_check("t5_m2", 8'd2, 15'h0ABC);
    rd_check("t5_m3", 8'd3, 15'h0303);

    do_reset("rst_err");

    // Bad high byte on the second word.
    send(8'd2);
    send(8'h00); send(8'h01);
    send(8'h80);
    check_eq("t6_err", load_err, 1);
    check_eq("t6_cpu_reset", cpu_reset, 1);
    check_eq("t6_ready", load_ready, 0);
    send(8'h00);
    check_eq("t6_err_hold", load_err, 1);
    @(negedge ph1);
    Adr      = 8'd1;
    MemWrite = 1'b1;
    wr_data  = 8'hEE;
    #1;
    check_eq("t6_rd_drive", rd_drive, 0);
    @(posedge ph1);
    #1;
    MemWrite = 1'b0;
    rd_check("t6_m0", 8'd0, 15'h0001);
    rd_check("t6_m1", 8'd1, 15'h5678);

    do_reset("rst_err_exit");

    // Reset after 3 of 5 bytes, then reload.
    send(8'd2); send(8'h11); send(8'h22);
    do_reset("rst_mid");
    rd_check("t7_keep", 8'd0, 15'h1122);
    send(8'd1); send(8'h01); send(8'h02);
    check_eq("t7_done", load_done, 1);
    rd_check("t7_m0", 8'd0, 15'h0102);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hmmm_mem_loader.md
# hmmm_mem_loader

Unified 256-word × 15-bit instruction/data memory with a byte-serial program loader, sitting directly downstream of the processor's memory bus (`Adr`, `MemWrite`, `MemData1`, `MemData2`). After reset it accepts a program image over a valid/ready byte stream while holding the processor in reset. Once the image is loaded, it releases the processor and serves its instruction fetches, loads and stores.

## Interface
Parameters:
- `DEPTH`, 256: number of memory words. Fixed by the 8-bit `Adr`; not user-changeable.

Ports:
- `ph1`  in  1  sole clock. All state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `load_valid`  in  1  host byte valid.
- `load_byte`  in  8  host byte.
- `load_ready`  out  1  loader can accept a byte.
- `cpu_reset`  out  1  active-high reset to the processor; 1 whenever not in RUN.
- `load_done`  out  1  1 in RUN.
- `load_err`  out  1  1 in ERR.
- `Adr`  in  8  processor address.
- `MemWrite`  in  1  processor store strobe.
- `wr_data`  in  8  processor store data (the processor's driven `MemData2`).
- `MemData1`  out  7  read word bits [14:8].
- `rd_data`  out  8  read word bits [7:0]; top level gates this onto `MemData2`.
- `rd_drive`  out  1  top level drives `rd_data` onto `MemData2` when 1; equals `load_done & ~MemWrite`.

## Operation
- FSM states: HDR, HI, LO, RUN, ERR. Reset state is HDR.
- A byte is accepted when `load_valid & load_ready` is 1 at a rising edge. `load_ready` = 1 in HDR, HI and LO; 0 in RUN and ERR.
- HDR, on accept:
  - `count` (9-bit) <= `load_byte`, except 0 encodes 256.
  - `waddr` (9-bit) <= 0.
  - Next state is HI.
- HI, on accept:
  - If `load_byte[7]` is 1, next state is ERR.
  - Otherwise `hi` <= `load_byte[6:0]` and next state is LO.
- LO, on accept:
  - `mem[waddr[7:0]]` <= `{hi, load_byte}`, and `waddr` increments.
  - If `waddr == count-1` before the increment, next state is RUN; otherwise next state is HI.
- RUN:
  - `load_valid` is ignored.
  - Read is combinational: `{MemData1, rd_data}` = `mem[Adr]`.
  - A store with `MemWrite`=1 at a rising edge writes `wr_data` into `mem[Adr][7:0]`; bits [14:8] are unchanged.
  - RUN is left only via `reset`.
- ERR is terminal until `reset`.
  - `cpu_reset`=1, `load_err`=1.
  - Memory is unchanged.
- Outside RUN:
  - `MemWrite` is ignored.
  - `MemData1` and `rd_data` still show `mem[Adr]`, but `rd_drive`=0.
- Memory array contents are not reset. Words past `count` keep their prior values, which are undefined after power-up.

## Timing
- On asynchronous assertion of `reset`:
  - State goes to HDR immediately; `count` and `waddr` clear.
  - Outputs become `cpu_reset`=1, `load_ready`=1, `load_done`=0, `load_err`=0.
- Reset mid-load restarts at HDR. Words already written are retained.
- Every output except the read data is a decode of the registered state. Output changes appear after the accepting edge; no combinational path runs from `load_valid` to any output.
- `cpu_reset` falls on the same edge that accepts the final LO byte. The processor's first fetch (`Adr`=0) follows its own reset release.
- Load latency with no gaps is `1 + 2·count` accepted edges. Gaps in `load_valid` stall the FSM with no state change.
- Store and read of the same address in the same cycle: the read shows the old data until the edge.
- `waddr` counts to 256 without aliasing: with `count`=256, the last write goes to address 255.

## Test plan
- Load header 3 then bytes 00 15, 7F FF, 01 80:
  - mem[0..2] = 0x0015, 0x7FFF, 0x0180.
  - `cpu_reset` falls after the 7th accept.
  - Reads at `Adr` 0/1/2 return those words.
- Header 0, then 512 bytes of pattern hi=i[6:0], lo=i:
  - RUN is reached only after 256 words.
  - mem[255] = {7'h7F, 8'hFF}; mem[0] is not overwritten by a wrap.
- Header 2, bytes 00 01, 80 00:
  - ERR on the second high byte; `load_err`=1, `cpu_reset`=1, `load_ready`=0.
  - mem[1] is unchanged.
- Random `load_valid` gaps, with `load_valid` held at 1 during RUN:
  - Memory image is identical to the gap-free run.
  - No writes occur after RUN.
- In RUN with mem[0x20]=0x5A3C, store 0x77 to 0x20:
  - Read returns 0x5A77.
  - `rd_drive`=0 during the store cycle.
- Assert `reset` after 3 of 5 bytes, then reload with header 1, bytes 01 02:
  - Immediate HDR with `cpu_reset`=1.
  - After reload, mem[0]=0x0102.
